// File: rtl/alu8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu8_pkg
// Description : Shared opcode enumeration and data width for the alu8 slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu8_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    typedef enum logic [SEL_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NOR  = 4'd11,
        OP_NAND = 4'd12,
        OP_XNOR = 4'd13,
        OP_GT   = 4'd14,
        OP_EQ   = 4'd15
    } opcode_t;

endpackage : alu8_pkg
`default_nettype wire

// File: rtl/alu8_if.sv
`default_nettype none
// ============================================================================
// Module      : alu8_if
// Description : Operand/opcode bus and registered result/flag of the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu8_if;
    import alu8_pkg::*;

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] out;
    logic              Carryout;

    modport master (output a, b, sel, input  out, Carryout);
    modport slave  (input  a, b, sel, output out, Carryout);

endinterface : alu8_if
`default_nettype wire

// File: rtl/alu8_core.sv
`default_nettype none
// ============================================================================
// Module      : alu8_core
// Description : Combinational 16-function datapath {carry,result} = f(a,b,sel).
//               ALU_DIV_EN builds the divider for opcode 3; otherwise 0/0.
// Revision    : 1.0 - initial release
// ============================================================================
module alu8_core
    import alu8_pkg::*;
(
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    input  wire logic [SEL_W-1:0]  i_sel,
    output logic      [DATA_W-1:0] o_result,
    output logic                   o_carry
);

    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // Top bit of the widened difference is the borrow (a < b).
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

`ifdef ALU_DIV_EN
    logic [DATA_W-1:0] w_quot;
    assign w_quot = i_a / i_b;
`endif

    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (opcode_t'(i_sel))
            OP_ADD:  begin o_result = w_sum[DATA_W-1:0];  o_carry = w_sum[DATA_W];  end
            OP_SUB:  begin o_result = w_diff[DATA_W-1:0]; o_carry = w_diff[DATA_W]; end
            OP_MUL:  begin
                o_result = w_prod[DATA_W-1:0];
                o_carry  = |w_prod[2*DATA_W-1:DATA_W];
            end
            OP_DIV:  begin
`ifdef ALU_DIV_EN
                if (i_b == '0) begin
                    o_result = '1;
                    o_carry  = 1'b1;
                end else begin
                    o_result = w_quot;
                end
`else
                o_result = '0;
`endif
            end
            OP_SHL:  begin o_result = {i_a[DATA_W-2:0], 1'b0}; o_carry = i_a[DATA_W-1]; end
            OP_SHR:  begin o_result = {1'b0, i_a[DATA_W-1:1]}; o_carry = i_a[0];        end
            OP_ROL:  o_result = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
            OP_ROR:  o_result = {i_a[0], i_a[DATA_W-1:1]};
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_NOR:  o_result = ~(i_a | i_b);
            OP_NAND: o_result = ~(i_a & i_b);
            OP_XNOR: o_result = ~(i_a ^ i_b);
            OP_GT:   o_result = {{(DATA_W-1){1'b0}}, (i_a > i_b)};
            OP_EQ:   o_result = {{(DATA_W-1){1'b0}}, (i_a == i_b)};
            default: o_result = '0;
        endcase
    end

endmodule : alu8_core
`default_nettype wire

// File: rtl/alu8_reg.sv
`default_nettype none
// ============================================================================
// Module      : alu8_reg
// Description : 8-bit ALU with one-cycle registered result and carry flag.
//               Optional divider enabled by defining ALU_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu8_reg
    import alu8_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    alu8_if.slave     bus
);

    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic [DATA_W-1:0] r_out;
    logic              r_carry;

    alu8_core u_core (
        .i_a      (bus.a),
        .i_b      (bus.b),
        .i_sel    (bus.sel),
        .o_result (w_result),
        .o_carry  (w_carry)
    );

    // Asynchronous clear drops any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_out   <= w_result;
            r_carry <= w_carry;
        end
    end

    assign bus.out      = r_out;
    assign bus.Carryout = r_carry;

endmodule : alu8_reg
`default_nettype wire

// File: tb/tb_alu8_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu8_reg
// Description : Self-checking bench: directed table, reset sequences and
//               random vectors against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu8_reg;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu8_if bus ();

    alu8_reg u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] eout;
        logic       ec;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] eout, input logic ec);
        total++;
        if (bus.out !== eout || bus.Carryout !== ec) begin
            bad++;
            $display("FAIL %s: got out=%h C=%b, expected out=%h C=%b",
                     name, bus.out, bus.Carryout, eout, ec);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bus.a   = a;
        bus.b   = b;
        bus.sel = sel;
    endtask

    // One operation: drive, clock, then sample 1 ns after the edge.
    task automatic apply(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [7:0] eout, input logic ec);
        drive(a, b, sel);
        @(posedge clk);
        #1;
        check(name, eout, ec);
    endtask

    function automatic logic [8:0] ref_alu(input int a, input int b, input int s);
        int o;
        int c;
        o = 0;
        c = 0;
        case (s)
            0:  begin o = (a + b) % 256;       c = (a + b > 255) ? 1 : 0; end
            1:  begin o = (a - b + 256) % 256; c = (a < b) ? 1 : 0;       end
            2:  begin o = (a * b) % 256;       c = (a * b > 255) ? 1 : 0; end
            3:  begin
`ifdef ALU_DIV_EN
                if (b == 0) begin o = 255; c = 1; end
                else o = a / b;
`endif
            end
            4:  begin o = (a * 2) % 256; c = a / 128; end
            5:  begin o = a / 2;         c = a % 2;   end
            6:  o = (a * 2) % 256 + a / 128;
            7:  o = a / 2 + (a % 2) * 128;
            8:  o = a & b;
            9:  o = a | b;
            10: o = a ^ b;
            11: o = 255 - (a | b);
            12: o = 255 - (a & b);
            13: o = 255 - (a ^ b);
            14: o = (a > b) ? 1 : 0;
            15: o = (a == b) ? 1 : 0;
            default: o = 0;
        endcase
        return {c[0], o[7:0]};
    endfunction

    initial begin
        logic [7:0] sweep_out [16];
        logic [7:0] ra, rb;
        logic [3:0] rs;
        logic [8:0] exp_v;

        sweep_out = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
`ifndef ALU_DIV_EN
        sweep_out[3] = 8'h00;
`endif
        for (int i = 0; i < 16; i++)
            vecs.push_back('{8'h0A, 8'h02, 4'(i), sweep_out[i], 1'b0});
        vecs.push_back('{8'hF6, 8'h0A, 4'd0,  8'h00, 1'b1});
        vecs.push_back('{8'h02, 8'h05, 4'd1,  8'hFD, 1'b1});
        vecs.push_back('{8'h10, 8'h10, 4'd2,  8'h00, 1'b1});
        vecs.push_back('{8'h81, 8'h00, 4'd4,  8'h02, 1'b1});
`ifdef ALU_DIV_EN
        vecs.push_back('{8'h10, 8'h00, 4'd3,  8'hFF, 1'b1});
`else
        vecs.push_back('{8'h10, 8'h00, 4'd3,  8'h00, 1'b0});
`endif
        vecs.push_back('{8'h0A, 8'h0A, 4'd15, 8'h01, 1'b0});
        vecs.push_back('{8'h0A, 8'h0A, 4'd14, 8'h00, 1'b0});
        vecs.push_back('{8'h0B, 8'h0A, 4'd14, 8'h01, 1'b0});
        vecs.push_back('{8'h81, 8'hFF, 4'd5,  8'h40, 1'b1});
        vecs.push_back('{8'h81, 8'hFF, 4'd7,  8'hC0, 1'b0});

        // Reset held with live operands that would otherwise give a carry.
        rst_n = 1'b0;
        drive(8'hF6, 8'h0A, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("first_add", 8'h0A, 8'h02, 4'd0, 8'h0C, 1'b0);

        foreach (vecs[i])
            apply($sformatf("vec%0d_sel%0d", i, vecs[i].sel),
                  vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].eout, vecs[i].ec);

        // Mid-stream asynchronous reset clears outputs before the next edge.
        apply("pre_reset", 8'h02, 8'h05, 4'd1, 8'hFD, 1'b1);
        drive(8'h0A, 8'h02, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("reset_discards", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_reset", 8'h0A, 8'h02, 4'd2, 8'h14, 1'b0);

        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            exp_v = ref_alu(int'(ra), int'(rb), int'(rs));
            apply($sformatf("rand%0d_sel%0d_a%h_b%h", n, rs, ra, rb),
                  ra, rb, rs, exp_v[7:0], exp_v[8]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu8_reg
`default_nettype wire
